mb_uart_rx: RTL

- Modbus serial receive front end. Sits directly upstream of the baud-rate generator.
- Detects the start bit on the synchronised RX line and raises bps_start. Samples one bit per bps_flag pulse (bit midpoint) and assembles 8N1 bytes, LSB first.
- Also flags the Modbus RTU inter-frame silence (t3.5) so the framing layer can delimit frames.

---
 rtl/mb_uart_rx_if.sv | 31 +++
 rtl/mb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mb_uart_rx_if.sv
// Bus bundle between the Modbus RX front end and its neighbours.
// The master side drives the serial line and the bit-midpoint strobe from
// the baud generator. The slave side, which is the receiver, returns the
// generator enable, the byte, the status strobes and a debug view of the
// FSM state.
//
// Handshake: rx_valid, rx_ferr, rx_perr and frame_end are single-cycle
// strobes. There is no ready signal and no backpressure. A consumer samples
// rx_data in the cycle rx_valid is high. rx_data also holds its value until
// the next good byte arrives.
interface mb_uart_rx_if;
  logic       rs232_rx;
  logic       bps_flag;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_perr;
  logic       frame_end;
  logic [2:0] dbg_state;

  modport master (
    output rs232_rx, bps_flag,
    input  bps_start, rx_data, rx_valid, rx_ferr, rx_perr, frame_end, dbg_state
  );

  modport slave (
    input  rs232_rx, bps_flag,
    output bps_start, rx_data, rx_valid, rx_ferr, rx_perr, frame_end, dbg_state
  );
endinterface

// File: rtl/mb_uart_rx.sv
// Modbus serial receive front end.
// - Synchronises the RX line and detects the start edge.
// - Enables the external baud generator through bps_start.
// - Samples one bit per bps_flag and assembles bytes LSB first.
// - Reports good bytes and framing errors.
// - Flags the RTU t3.5 inter-frame silence with frame_end.
// Optional: define MB_UART_PARITY_EN for 8E1 frames with an extra PAR state
// and parity-error reporting. Without it the frame is 8N1 and rx_perr is 0.
module mb_uart_rx #(
  parameter int CLK_FRQ  = 50_000_000,
  parameter int BPS_SET  = 115200,
  parameter int GAP_BITS = 39,
  parameter int GAP_CLKS = (CLK_FRQ / BPS_SET) * GAP_BITS,
  parameter int GAP_W    = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  mb_uart_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CLKS);
  localparam logic [GAP_W-1:0] GAP_HIT = GAP_W'(GAP_CLKS - 1);

  state_t           state_q;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic             rx_dly_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic             bps_start_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             rx_ferr_q;
  logic             byte_seen_q;
  logic             frame_end_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [GAP_W-1:0] gap_cnt_d;
  logic             fall_edge;
  logic             any_edge;
  logic             gap_hit;

`ifdef MB_UART_PARITY_EN
  logic             par_q;
  logic             rx_perr_q;
  logic             par_bad;
  // Even parity: the data bits and the parity bit XOR to 0 on a good frame.
  assign par_bad = (^shift_q) ^ par_q;
`endif

  // Line conditioning.
  // The synchroniser resets to 0, so a line that is already low when reset
  // is released cannot fake a start edge.
  assign fall_edge = rx_dly_q & ~rx_sync_q;
  assign any_edge  = rx_dly_q ^ rx_sync_q;
  assign gap_hit   = (gap_cnt_q == GAP_HIT) && byte_seen_q;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_dly_q  <= 1'b0;
    end else begin
      rx_meta_q <= bus.rs232_rx;
      rx_sync_q <= rx_meta_q;
      rx_dly_q  <= rx_sync_q;
    end
  end

  // Silence counter.
  // It counts clocks of steady-high idle line and saturates at the t3.5 length.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (any_edge || (state_q != IDLE)) begin
      gap_cnt_d = '0;
    end else if (rx_sync_q && (gap_cnt_q != GAP_MAX)) begin
      gap_cnt_d = gap_cnt_q + GAP_W'(1);
    end
  end

  // Silence counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Character FSM.
  // It also owns every output strobe, so all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      bps_start_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_ferr_q   <= 1'b0;
      byte_seen_q <= 1'b0;
      frame_end_q <= 1'b0;
`ifdef MB_UART_PARITY_EN
      par_q       <= 1'b0;
      rx_perr_q   <= 1'b0;
`endif
    end else begin
      rx_valid_q  <= 1'b0;
      rx_ferr_q   <= 1'b0;
      frame_end_q <= 1'b0;
`ifdef MB_UART_PARITY_EN
      rx_perr_q   <= 1'b0;
`endif
      // The silence counter only reaches GAP_HIT while idle.
      // A byte cannot complete in that same cycle.
      if (gap_hit) begin
        frame_end_q <= 1'b1;
        byte_seen_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (fall_edge) begin
            state_q     <= START;
            bps_start_q <= 1'b1;
          end
        end
        START: begin
          if (bus.bps_flag) begin
            if (!rx_sync_q) begin
              bit_cnt_q <= 3'd0;
              state_q   <= DATA;
            end else begin
              // Start bit was high at its midpoint: treat it as a glitch.
              bps_start_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        DATA: begin
          if (bus.bps_flag) begin
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef MB_UART_PARITY_EN
              state_q <= PAR;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef MB_UART_PARITY_EN
        PAR: begin
          if (bus.bps_flag) begin
            par_q   <= rx_sync_q;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (bus.bps_flag) begin
            bps_start_q <= 1'b0;
            state_q     <= IDLE;
            byte_seen_q <= 1'b1;
            if (!rx_sync_q) begin
              rx_ferr_q <= 1'b1;
`ifdef MB_UART_PARITY_EN
            end else if (par_bad) begin
              rx_perr_q <= 1'b1;
`endif
            end else begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          bps_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bps_start = bps_start_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_ferr   = rx_ferr_q;
  assign bus.frame_end = frame_end_q;
  assign bus.dbg_state = state_q;
`ifdef MB_UART_PARITY_EN
  assign bus.rx_perr   = rx_perr_q;
`else
  assign bus.rx_perr   = 1'b0;
`endif

endmodule
